multiexp_replay_sched: RTL and testbench



---
 rtl/multiexp_replay_sched.sv | 152 +++++++++++++++
 tb/tb_multiexp_replay_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiexp_replay_sched.sv
// Batch replay scheduler: stores up to MAX_IN point/scalar beats, then replays
// the stored batch ROUNDS times, tagging each beat with {round, channel}.
module multiexp_replay_sched #(
  parameter int DAT_BITS = 1024,
  parameter int MAX_IN   = 64,
  parameter int ROUNDS   = 256,
  parameter int NUM_CH   = 2,
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DAT_BITS-1:0] i_dat,
  input  logic                i_val,
  input  logic                i_sop,
  input  logic                i_eop,
  output logic                i_rdy,
  output logic [DAT_BITS-1:0] o_dat,
  output logic                o_val,
  output logic                o_sop,
  output logic                o_eop,
  input  logic                o_rdy,
  output logic [RW+CW-1:0]    o_ctl,
  output logic                o_err,
  output logic                o_busy,
  output logic [1:0]          dbg_state
);

  // Handshake: a beat moves on a rising edge only when val and rdy are both
  // high; a source holds its beat unchanged while val=1 and rdy=0.

  localparam int AW = (MAX_IN > 1) ? $clog2(MAX_IN) : 1;
  localparam int NW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, REPLAY} state_t;

  state_t state, state_next;

  logic [DAT_BITS-1:0] mem [MAX_IN];
  logic [NW-1:0] n;
  logic [AW-1:0] k, k_inc, wr_addr;
  logic [RW-1:0] r;
  logic [CW-1:0] ch, ch_inc;
  logic in_acc, out_acc, last_k, last_round, start, overflow;
  logic unused_sop;

  // Batch start is implied by leaving IDLE, so the input sop flag carries no information.
  assign unused_sop = i_sop;

  assign in_acc     = i_val && i_rdy;
  assign out_acc    = o_val && o_rdy;
  assign last_k     = ({1'b0, k} == n - NW'(1));
  assign last_round = (r == RW'(ROUNDS - 1));
  assign k_inc      = k + AW'(1);
  assign ch_inc     = (ch == CW'(NUM_CH - 1)) ? '0 : ch + CW'(1);
  assign wr_addr    = (state == IDLE) ? '0 : n[AW-1:0];

  assign o_sop     = o_val && (k == '0);
  assign o_eop     = o_val && last_k;
  assign o_ctl     = {r, ch};
  assign o_busy    = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    overflow   = 1'b0;
    case (state)
      IDLE: begin
        if (in_acc) begin
          state_next = i_eop ? REPLAY : LOAD;
          start      = i_eop;
        end
      end
      LOAD: begin
        if (in_acc) begin
          if (i_eop) begin
            state_next = REPLAY;
            start      = 1'b1;
          end else if (n == NW'(MAX_IN - 1)) begin
            state_next = DRAIN;
            overflow   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (in_acc && i_eop) begin
          state_next = REPLAY;
          start      = 1'b1;
        end
      end
      REPLAY: begin
        if (out_acc && last_k && last_round) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage is never cleared; n bounds what replay reads.
  always_ff @(posedge i_clk) begin
    if (in_acc && (state == IDLE || state == LOAD)) mem[wr_addr] <= i_dat;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      i_rdy <= 1'b0;
      o_err <= 1'b0;
      o_val <= 1'b0;
      o_dat <= '0;
      n     <= '0;
      k     <= '0;
      r     <= '0;
      ch    <= '0;
    end else begin
      i_rdy <= (state_next != REPLAY);
      o_err <= overflow;
      if (in_acc && state == IDLE)      n <= NW'(1);
      else if (in_acc && state == LOAD) n <= n + NW'(1);

      if (start) begin
        // A single-beat batch is still in flight to mem[0], so bypass it.
        o_dat <= (state == IDLE) ? i_dat : mem[0];
        o_val <= 1'b1;
        k     <= '0;
        r     <= '0;
        ch    <= '0;
      end else if (state == REPLAY && out_acc) begin
        if (last_k && last_round) begin
          o_val <= 1'b0;
          k     <= '0;
          r     <= '0;
          ch    <= '0;
        end else if (last_k) begin
          o_dat <= mem[0];
          k     <= '0;
          r     <= r + RW'(1);
          ch    <= '0;
        end else begin
          o_dat <= mem[k_inc];
          k     <= k_inc;
          ch    <= ch_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiexp_replay_sched.sv
// Directed bench for multiexp_replay_sched with MAX_IN=4, ROUNDS=3, NUM_CH=2.
module tb_multiexp_replay_sched;

  localparam int DW = 16;
  localparam int W  = DW + 2 + 3;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [DW-1:0] i_dat = '0;
  logic          i_val = 1'b0;
  logic          i_sop = 1'b0;
  logic          i_eop = 1'b0;
  logic          i_rdy;
  logic [DW-1:0] o_dat;
  logic          o_val, o_sop, o_eop;
  logic          o_rdy = 1'b1;
  logic [2:0]    o_ctl;
  logic          o_err, o_busy;
  logic [1:0]    dbg_state;

  multiexp_replay_sched #(.DAT_BITS(DW), .MAX_IN(4), .ROUNDS(3), .NUM_CH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dat(i_dat), .i_val(i_val), .i_sop(i_sop),
    .i_eop(i_eop), .i_rdy(i_rdy), .o_dat(o_dat), .o_val(o_val), .o_sop(o_sop),
    .o_eop(o_eop), .o_rdy(o_rdy), .o_ctl(o_ctl), .o_err(o_err), .o_busy(o_busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt  = 0;
  int last_out_edge = 0;
  int rdy_mode = 0;
  logic [W-1:0] held;
  logic         held_v = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] beat(input logic [DW-1:0] d, input logic sop,
                                        input logic eop, input int r, input int ch);
    logic [1:0] rr;
    logic       cc;
    rr = r[1:0];
    cc = ch[0];
    return {d, sop, eop, rr, cc};
  endfunction

  // Expected replay of a batch: 3 passes, sop on first entry, eop on last, ch = k mod 2.
  task automatic push_batch(input logic [DW-1:0] d0, d1, d2, d3, input int n);
    logic [DW-1:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < n; k++)
        exp_q.push_back(beat(d[k], k == 0, k == n - 1, r, k % 2));
  endtask

  // o_rdy driver: 0 = always ready, 1 = toggle every cycle, 2 = held low
  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      case (rdy_mode)
        1:       o_rdy = ~o_rdy;
        2:       o_rdy = 1'b0;
        default: o_rdy = 1'b1;
      endcase
    end
  end

  // output monitor, sampled mid-cycle
  initial begin
    logic [W-1:0] cur;
    forever begin
      @(negedge i_clk);
      cur = {o_dat, o_sop, o_eop, o_ctl};
      if (held_v && o_val) check("hold_stable", cur, held);
      held_v = o_val && !o_rdy;
      held   = cur;
      if (o_val) check("in_rdy_replay", i_rdy, 1'b0);
      if (o_val && o_rdy) begin
        check("beat_avail", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("beat", cur, exp_q.pop_front());
        acc_cnt++;
        last_out_edge = cyc + 1;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [DW-1:0] d, input logic sop, input logic eop);
    bit done = 0;
    i_val = 1'b1; i_dat = d; i_sop = sop; i_eop = eop;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge i_clk);
      if (i_rdy) begin
        @(posedge i_clk);
        #1;
        done = 1;
      end
    end
    check("send_accept", done, 1'b1);
    i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 300; t++) begin
      if (exp_q.size() == 0 && !o_val) break;
      @(posedge i_clk);
      #1;
    end
    check("drained", exp_q.size(), 0);
    check("busy_end", o_busy, 1'b0);
    check("in_rdy_end", i_rdy, 1'b1);
  endtask

  initial begin
    int base;
    int r_edge;

    // reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_o_val", o_val, 1'b0);
    check("rst_i_rdy", i_rdy, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_ctl", o_ctl, 3'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("rdy_after_rst", i_rdy, 1'b1);

    // three-pair batch
    push_batch(16'h00A1, 16'h00B2, 16'h00C3, 16'h0, 3);
    send(16'h00A1, 1, 0);
    send(16'h00B2, 0, 0);
    check("busy_load", o_busy, 1'b1);
    send(16'h00C3, 0, 1);
    check("lat_abc", o_val, 1'b1);
    wait_done();

    // single pair: sop and eop together on every pass
    push_batch(16'h1111, 16'h0, 16'h0, 16'h0, 1);
    send(16'h1111, 1, 1);
    check("lat_single", o_val, 1'b1);
    wait_done();

    // overflow: E,F discarded
    push_batch(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 4);
    send(16'h0A0A, 1, 0);
    send(16'h0B0B, 0, 0);
    send(16'h0C0C, 0, 0);
    check("err_before", o_err, 1'b0);
    send(16'h0D0D, 0, 0);
    check("err_pulse", o_err, 1'b1);
    send(16'h0E0E, 0, 0);
    check("err_once", o_err, 1'b0);
    check("drain_busy", o_busy, 1'b1);
    send(16'h0F0F, 0, 1);
    check("lat_drain", o_val, 1'b1);
    wait_done();

    // back-pressure toggling every cycle
    rdy_mode = 1;
    push_batch(16'h2222, 16'h3333, 16'h0, 16'h0, 2);
    send(16'h2222, 1, 0);
    send(16'h3333, 0, 1);
    check("lat_stall", o_val, 1'b1);
    wait_done();
    rdy_mode = 0;
    @(posedge i_clk); #1;

    // reset after fourth output beat
    push_batch(16'h4444, 16'h5555, 16'h6666, 16'h0, 3);
    base = acc_cnt;
    send(16'h4444, 1, 0);
    send(16'h5555, 0, 0);
    send(16'h6666, 0, 1);
    for (int t = 0; t < 100; t++) begin
      if (acc_cnt >= base + 4) break;
      @(posedge i_clk); #1;
    end
    check("rst_beats_seen", acc_cnt - base, 4);
    i_rst = 1'b0;
    rdy_mode = 2;
    @(posedge i_clk); #1;
    check("midrst_o_val", o_val, 1'b0);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_i_rdy", i_rdy, 1'b0);
    check("midrst_left", exp_q.size(), 5);
    exp_q.delete();
    i_rst = 1'b1;
    rdy_mode = 0;
    @(posedge i_clk); #1;
    check("midrst_rdy_back", i_rdy, 1'b1);
    check("midrst_no_out", o_val, 1'b0);
    push_batch(16'h7777, 16'h0, 16'h0, 16'h0, 1);
    send(16'h7777, 1, 1);
    check("lat_x", o_val, 1'b1);
    wait_done();

    // back-to-back batches: second held off until replay finishes
    push_batch(16'h8888, 16'h9999, 16'h0, 16'h0, 2);
    push_batch(16'hABCD, 16'h0, 16'h0, 16'h0, 1);
    send(16'h8888, 1, 0);
    send(16'h9999, 0, 1);
    send(16'hABCD, 1, 1);
    r_edge = cyc;
    check("b2b_edge", r_edge, last_out_edge + 1);
    check("lat_b2b", o_val, 1'b1);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
